mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequencing controller and two-port arbiter in front of the single-ported main memory.
- Shares the memory between the instruction-fetch port (read-only) and the data port (read/write).
- Drives the memory's read/write strobes, waits on its data-ready flag and returns the dataGrabbed acknowledge.
- Delivers one-cycle ack pulses to the requesters. Sits between the CPU datapath and main memory.

Parameters:
- WRITE_CYCLES, 2: cycles memWrite is held high per write (min 1).
- TIMEOUT, 16: max cycles waited for memDataReady to rise, or to fall after dataGrabbed (min 2).
- ROUND_ROBIN, 0: 0 = data port has fixed priority; 1 = alternate grants when both ports request.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ifReq  in  1  instruction-fetch read request (level).
- ifAddr  in  32  fetch address.
- ifData  out  32  fetched word; valid when ifAck=1.
- ifAck  out  1  one-cycle completion pulse to the fetch port.
- dReq  in  1  data-port request (level).
- dWrite  in  1  1 = write, 0 = read; sampled with dReq.
- dAddr  in  32  data address.
- dWData  in  32  write data.
- dRData  out  32  read data; valid when dAck=1.
- dAck  out  1  one-cycle completion pulse to the data port.
- memAddress  out  32  address to memory.
- memWriteData  out  32  write data to memory.
- memRead  out  1  read strobe.
- memWrite  out  1  write strobe.
- memReadData  in  32  read data from memory.
- memDataReady  in  1  memory read-data-valid flag.
- dataGrabbed  out  1  tells memory the read data was captured.
- busy  out  1  1 whenever state != IDLE.
- timeoutErr  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State = IDLE; all outputs 0, including ifData, dRData, memAddress and memWriteData.
  - Round-robin pointer selects the data port as the next winner.
  - timeoutErr cleared; timeout counter cleared.
  - Reset mid-transaction aborts it with no ack; memRead and memWrite drop on the reset edge.
- States: IDLE, RD_REQ, RD_GRAB, WR_HOLD, ACK.
- IDLE:
  - If any request is present, grant one port and latch its address into memAddress.
  - For a data write, also latch dWData into memWriteData.
  - Next state is RD_REQ or WR_HOLD; the counter clears.
  - Grant when both request: ROUND_ROBIN=0 → data port. ROUND_ROBIN=1 → the port not granted last; the pointer updates on every grant.
  - Requests are sampled only in IDLE; address and data are latched once and held for the whole transaction.
- RD_REQ:
  - memRead=1.
  - If memDataReady=1: capture memReadData into the granted port's output register, then go to RD_GRAB.
  - Else, if counter==TIMEOUT-1: set timeoutErr, load 32'h0 into the output register, go to ACK.
  - Otherwise the counter increments.
- RD_GRAB:
  - memRead=0, dataGrabbed=1.
  - When memDataReady=0, go to ACK.
  - Timeout applies here too: set timeoutErr and go to ACK; captured data is kept.
  - The counter clears on entry.
- WR_HOLD:
  - memWrite=1 for exactly WRITE_CYCLES cycles, then go to ACK.
  - memDataReady is ignored.
- ACK:
  - Granted port's ack=1 for exactly one cycle; strobes are 0.
  - Next state is IDLE.
  - Output data registers hold their value until the next capture.
- Throughput:
  - A requester holding req through ack is treated as a new request in the following IDLE cycle.
  - Minimum spacing between acks is therefore one idle cycle.
- Latency:
  - Read with ready on the 1st RD_REQ cycle, and low on the 1st RD_GRAB cycle: req edge → ack = 4 cycles (IDLE, RD_REQ, RD_GRAB, ACK).
  - Write: 2 + WRITE_CYCLES cycles.
- Invariants:
  - memRead and memWrite are never both 1.
  - dataGrabbed is never 1 while memRead=1.
  - ifAck and dAck are never both 1.
  - The fetch port never causes memWrite.

Test Plan:
- Single fetch:
  - Stimulus: ifReq=1, ifAddr=0x40; memory model raises ready 2 cycles after memRead with 0x8C090004, drops it 1 cycle after dataGrabbed.
  - Required: ifAck one cycle, ifData=0x8C090004, memWrite=0 throughout.
- Data write with WRITE_CYCLES=2:
  - Stimulus: dReq=1, dWrite=1, dAddr=0x10, dWData=0xCAFEF00D.
  - Required: memWrite high exactly 2 cycles with memAddress=0x10 and memWriteData=0xCAFEF00D, then dAck pulse.
- Contention:
  - Stimulus: ifReq and dReq rise in the same cycle and are held for 4 transactions.
  - Required with ROUND_ROBIN=0: data port served every time.
  - Required with ROUND_ROBIN=1: order is D, I, D, I.
- Read timeout with TIMEOUT=16:
  - Stimulus: memDataReady held at 0.
  - Required: after 16 RD_REQ cycles, timeoutErr=1, dAck pulse, dRData=0.
  - Required: timeoutErr remains 1 across the next good transaction.
- Reset mid-read:
  - Stimulus: rst_n=0 during RD_REQ.
  - Required: next edge gives state IDLE, memRead=0, no ack, busy=0, all outputs 0.
- Back-to-back:
  - Stimulus: dReq held high for two reads at 0x20 and 0x24.
  - Required: two dAck pulses separated by exactly one idle cycle, each with the correct data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-ported main memory.
// Fetch port is read-only; data port reads or writes. One transaction at a time.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no transaction; sample requests, grant, latch address/data
// RD_REQ  | memRead high, waiting for memDataReady
// RD_GRAB | dataGrabbed high, waiting for memDataReady to drop
// WR_HOLD | memWrite high for WRITE_CYCLES cycles
// ACK     | one-cycle ack to the granted port
module mem_arbiter #(
  parameter int WRITE_CYCLES = 2,
  parameter int TIMEOUT      = 16,
  parameter int ROUND_ROBIN  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifData,
  output logic        ifAck,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWData,
  output logic [31:0] dRData,
  output logic        dAck,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] memReadData,
  input  logic        memDataReady,
  output logic        dataGrabbed,
  output logic        busy,
  output logic        timeoutErr
);

  localparam int CMAX = (TIMEOUT > WRITE_CYCLES) ? TIMEOUT : WRITE_CYCLES;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_GRAB, WR_HOLD, ACK} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gnt_d;
  logic          rr_d;
  logic          pick_d;
  logic          start, start_wr, cap_rd, cap_zero, set_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Timers count down from their limit; terminal count is zero.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    start       = 1'b0;
    start_wr    = 1'b0;
    cap_rd      = 1'b0;
    cap_zero    = 1'b0;
    set_err     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    dataGrabbed = 1'b0;
    ifAck       = 1'b0;
    dAck        = 1'b0;
    pick_d      = dReq && (!ifReq || (ROUND_ROBIN == 0) || rr_d);
    case (state)
      IDLE: begin
        if (ifReq || dReq) begin
          start     = 1'b1;
          start_wr  = pick_d && dWrite;
          state_nxt = start_wr ? WR_HOLD : RD_REQ;
          cnt_nxt   = start_wr ? CW'(WRITE_CYCLES - 1) : CW'(TIMEOUT - 1);
        end
      end
      RD_REQ: begin
        memRead = 1'b1;
        if (memDataReady) begin
          cap_rd    = 1'b1;
          state_nxt = RD_GRAB;
          cnt_nxt   = CW'(TIMEOUT - 1);
        end else if (cnt == '0) begin
          set_err   = 1'b1;
          cap_zero  = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RD_GRAB: begin
        dataGrabbed = 1'b1;
        if (!memDataReady) begin
          state_nxt = ACK;
        end else if (cnt == '0) begin
          set_err   = 1'b1;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      WR_HOLD: begin
        memWrite = 1'b1;
        if (cnt == '0) state_nxt = ACK;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ACK: begin
        ifAck     = !gnt_d;
        dAck      = gnt_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_d        <= 1'b0;
      rr_d         <= 1'b1;
      memAddress   <= '0;
      memWriteData <= '0;
      ifData       <= '0;
      dRData       <= '0;
      timeoutErr   <= 1'b0;
    end else begin
      if (start) begin
        gnt_d      <= pick_d;
        rr_d       <= !pick_d;
        memAddress <= pick_d ? dAddr : ifAddr;
        if (start_wr) memWriteData <= dWData;
      end
      // A read timeout returns zero so the requester never sees stale data.
      if (cap_rd || cap_zero) begin
        if (gnt_d) dRData <= cap_rd ? memReadData : '0;
        else       ifData <= cap_rd ? memReadData : '0;
      end
      if (set_err) timeoutErr <= 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-priority and round-robin instances share stimulus,
// each with its own small memory model; table of single transactions plus corner sequences.
module tb_mem_arbiter;

  localparam int NEVER = 99;

  typedef struct {
    bit          port_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_data;
    int          exp_lat;
    bit          exp_err;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifReq, dReq, dWrite;
  logic [31:0] ifAddr, dAddr, dWData;

  logic [31:0] ifData [2];
  logic [31:0] dRData [2];
  logic [31:0] mAddr  [2];
  logic [31:0] mWData [2];
  logic [31:0] mRData [2];
  logic [1:0]  ifAck, dAck, mRd, mWr, mRdy, mGr, busy, terr;

  logic [1:0]  rdy_r = '0;
  int          rc [2] = '{0, 0};
  int          mdelay = 0;

  int          pass = 0, total = 0;
  int          viol = 0, wcnt = 0, wbad = 0;
  logic [31:0] exp_waddr = '0, exp_wdata = '0;
  bit          ackq0 [$];
  bit          ackq1 [$];

  always #5 clk = ~clk;

  mem_arbiter #(.WRITE_CYCLES(2), .TIMEOUT(16), .ROUND_ROBIN(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData[0]), .ifAck(ifAck[0]),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData[0]), .dAck(dAck[0]),
    .memAddress(mAddr[0]), .memWriteData(mWData[0]), .memRead(mRd[0]), .memWrite(mWr[0]),
    .memReadData(mRData[0]), .memDataReady(mRdy[0]), .dataGrabbed(mGr[0]),
    .busy(busy[0]), .timeoutErr(terr[0])
  );

  mem_arbiter #(.WRITE_CYCLES(2), .TIMEOUT(16), .ROUND_ROBIN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData[1]), .ifAck(ifAck[1]),
    .dReq(dReq), .dWrite(dWrite), .dAddr(dAddr), .dWData(dWData),
    .dRData(dRData[1]), .dAck(dAck[1]),
    .memAddress(mAddr[1]), .memWriteData(mWData[1]), .memRead(mRd[1]), .memWrite(mWr[1]),
    .memReadData(mRData[1]), .memDataReady(mRdy[1]), .dataGrabbed(mGr[1]),
    .busy(busy[1]), .timeoutErr(terr[1])
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C090004;
      32'h20:  return 32'h11112020;
      32'h24:  return 32'h22224242;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Memory model: delay 0 = ready combinationally with memRead, NEVER = no ready,
  // otherwise ready rises after `delay` clocks of memRead and drops one clock after dataGrabbed.
  assign mRData[0] = mem_data(mAddr[0]);
  assign mRData[1] = mem_data(mAddr[1]);
  assign mRdy[0]   = (mdelay == 0) ? mRd[0] : rdy_r[0];
  assign mRdy[1]   = (mdelay == 0) ? mRd[1] : rdy_r[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rdy_r[i]) begin
        if (mGr[i]) rdy_r[i] <= 1'b0;
      end else if (mRd[i] && mdelay != 0 && mdelay != NEVER) begin
        if (rc[i] == mdelay - 1) begin
          rdy_r[i] <= 1'b1;
          rc[i]    <= 0;
        end else begin
          rc[i] <= rc[i] + 1;
        end
      end else begin
        rc[i] <= 0;
      end
    end
  end

  always begin
    @(posedge clk);
    #3;
    for (int i = 0; i < 2; i++) begin
      if (mRd[i] && mWr[i]) viol++;
      if (mGr[i] && mRd[i]) viol++;
      if (ifAck[i] && dAck[i]) viol++;
    end
    if (ifAck[0] || dAck[0]) ackq0.push_back(dAck[0]);
    if (ifAck[1] || dAck[1]) ackq1.push_back(dAck[1]);
    if (mWr[0]) begin
      wcnt++;
      if (mAddr[0] !== exp_waddr || mWData[0] !== exp_wdata) wbad++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else pass++;
  endtask

  task automatic run_txn(input txn_t t, input int idx);
    int lat;
    bit got;
    string nm;
    nm        = $sformatf("vec%0d", idx);
    mdelay    = t.delay;
    wcnt      = 0;
    wbad      = 0;
    exp_waddr = t.addr;
    exp_wdata = t.wdata;
    if (t.port_d) begin
      dReq = 1'b1; dWrite = t.wr; dAddr = t.addr; dWData = t.wdata;
    end else begin
      ifReq = 1'b1; ifAddr = t.addr;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (ifAck[0] || dAck[0]) got = 1'b1;
    end
    ifReq = 1'b0;
    dReq  = 1'b0;
    chk({nm, "_ack_seen"}, 32'(got), 32'd1);
    chk({nm, "_ack_port"}, {30'd0, dAck[0], ifAck[0]}, t.port_d ? 32'd2 : 32'd1);
    chk({nm, "_latency"}, 32'(lat + 1), 32'(t.exp_lat));
    if (t.wr) chk({nm, "_wr_addr_data"}, 32'(wbad), 32'd0);
    else      chk({nm, "_rdata"}, t.port_d ? dRData[0] : ifData[0], t.exp_data);
    chk({nm, "_wr_cycles"}, 32'(wcnt), t.wr ? 32'd2 : 32'd0);
    chk({nm, "_timeout_err"}, 32'(terr[0]), 32'(t.exp_err));
    @(negedge clk);
    chk({nm, "_post_idle"}, {29'd0, ifAck[0], dAck[0], busy[0]}, 32'd0);
  endtask

  txn_t        vec [7];
  int          n;
  bit          got;
  logic [3:0]  s0, s1;

  initial begin
    vec[0] = '{1'b0, 1'b0, 32'h40, 32'h0,        2,     32'h8C090004, 7,  1'b0};
    vec[1] = '{1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 0,     32'h0,        4,  1'b0};
    vec[2] = '{1'b1, 1'b0, 32'h10, 32'h0,        0,     32'h0010FFEF, 4,  1'b0};
    vec[3] = '{1'b0, 1'b0, 32'h44, 32'h0,        1,     32'h0044FFBB, 6,  1'b0};
    vec[4] = '{1'b1, 1'b0, 32'h80, 32'h0,        NEVER, 32'h0,        18, 1'b1};
    vec[5] = '{1'b0, 1'b0, 32'h40, 32'h0,        0,     32'h8C090004, 4,  1'b1};
    vec[6] = '{1'b1, 1'b1, 32'h14, 32'h12345678, 0,     32'h0,        4,  1'b1};

    rst_n = 1'b0; ifReq = 1'b0; dReq = 1'b0; dWrite = 1'b0;
    ifAddr = '0; dAddr = '0; dWData = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {26'd0, busy[0], ifAck[0], dAck[0], mRd[0], mWr[0], terr[0]}, 32'd0);
    chk("rst_ifdata", ifData[0], 32'd0);
    chk("rst_drdata", dRData[0], 32'd0);
    chk("rst_memaddr", mAddr[0], 32'd0);
    chk("rst_memwdata", mWData[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_txn(vec[i], i);

    // back-to-back reads with dReq held through the first ack
    mdelay = 0;
    dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h20;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (dAck[0]) got = 1'b1;
    end
    chk("b2b_ack1", 32'(got), 32'd1);
    chk("b2b_data1", dRData[0], 32'h11112020);
    dAddr = 32'h24;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("b2b_idle_gap", 32'(busy[0]), 32'd0);
      if (n == 2) chk("b2b_regrant", 32'(busy[0]), 32'd1);
      if (dAck[0]) got = 1'b1;
    end
    dReq = 1'b0;
    chk("b2b_ack_spacing", 32'(n), 32'd4);
    chk("b2b_data2", dRData[0], 32'h22224242);
    @(negedge clk);

    // reset in the middle of a read
    mdelay = NEVER;
    dReq = 1'b1; dWrite = 1'b0; dAddr = 32'h30;
    repeat (3) @(negedge clk);
    chk("midrd_reading", {30'd0, mRd[0], busy[0]}, 32'd3);
    rst_n = 1'b0;
    dReq  = 1'b0;
    @(negedge clk);
    chk("midrd_ctrl", {25'd0, busy[0], ifAck[0], dAck[0], mRd[0], mWr[0], mGr[0], terr[0]}, 32'd0);
    chk("midrd_ifdata", ifData[0], 32'd0);
    chk("midrd_drdata", dRData[0], 32'd0);
    chk("midrd_memaddr", mAddr[0], 32'd0);
    chk("midrd_memwdata", mWData[0], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrd_no_late_ack", {30'd0, ifAck[0], dAck[0]}, 32'd0);

    // contention: both ports held for four transactions
    mdelay = 0;
    ackq0.delete();
    ackq1.delete();
    ifAddr = 32'h40; dAddr = 32'h20; dWrite = 1'b0;
    ifReq = 1'b1; dReq = 1'b1;
    for (int k = 0; k < 100 && ackq0.size() < 4; k++) @(negedge clk);
    ifReq = 1'b0; dReq = 1'b0;
    repeat (3) @(negedge clk);
    s0 = '0;
    s1 = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < ackq0.size()) s0[3-k] = ackq0[k];
      if (k < ackq1.size()) s1[3-k] = ackq1[k];
    end
    chk("cont_fixed_count", 32'(ackq0.size()), 32'd4);
    chk("cont_rr_count", 32'(ackq1.size()), 32'd4);
    chk("cont_fixed_order", {28'd0, s0}, 32'hF);
    chk("cont_rr_order", {28'd0, s1}, 32'hA);
    chk("cont_rr_ifdata", ifData[1], 32'h8C090004);

    chk("invariants", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
